// File: rtl/impl_id_tx.sv
// Implementation-identification transmitter: streams a build-selected ASCII ID string
// plus an XOR checksum byte over valid/ready. String chosen by macro IMPL_ID_FOUNDRY_EN.
module impl_id_tx #(
    parameter int STR_LEN = 30
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_i,
    input  logic       abort_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       tx_valid_o,
    input  logic       tx_ready_i,
    output logic [7:0] tx_data_o,
    output logic       tx_last_o
);

    localparam int ROM_LEN = 30;
`ifdef IMPL_ID_FOUNDRY_EN
    localparam logic [8*ROM_LEN-1:0] ID_STR = "Foundry implementation of baz.";
`else
    localparam logic [8*ROM_LEN-1:0] ID_STR = "Generic implementation of baz.";
`endif
    localparam logic [7:0] LAST_IDX = 8'(STR_LEN - 1);

    typedef enum logic [1:0] {IDLE, SEND, CSUM} state_t;

    // String literal packs byte 0 in the MSBs; anything past the string reads as zero.
    function automatic logic [7:0] rom_byte(input logic [7:0] i);
        logic [7:0] b;
        b = 8'h00;
        if (int'(i) < ROM_LEN && int'(i) < STR_LEN)
            b = ID_STR[8*(ROM_LEN-1-int'(i)) +: 8];
        return b;
    endfunction

    state_t     state_q, state_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] csum_q, csum_d;
    logic       valid_q, valid_d;
    logic       last_q, last_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [7:0] data_q, data_d;
    logic       hs, to_idle;
    logic [7:0] csum_nx;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        csum_d  = csum_q;
        valid_d = valid_q;
        last_d  = last_q;
        busy_d  = busy_q;
        data_d  = data_q;
        done_d  = 1'b0;
        to_idle = 1'b0;
        hs      = valid_q && tx_ready_i;
        csum_nx = csum_q ^ rom_byte(idx_q);
        case (state_q)
            IDLE: begin
                if (req_i && !abort_i) begin
                    state_d = SEND;
                    idx_d   = 8'd0;
                    csum_d  = 8'd0;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    last_d  = 1'b0;
                    data_d  = rom_byte(8'd0);
                end
            end
            SEND: begin
                if (abort_i) begin
                    to_idle = 1'b1;
                end else if (hs) begin
                    csum_d = csum_nx;
                    if (idx_q == LAST_IDX) begin
                        state_d = CSUM;
                        last_d  = 1'b1;
                        data_d  = csum_nx;
                    end else begin
                        idx_d  = idx_q + 8'd1;
                        data_d = rom_byte(idx_q + 8'd1);
                    end
                end
            end
            CSUM: begin
                if (abort_i) begin
                    to_idle = 1'b1;
                end else if (hs) begin
                    to_idle = 1'b1;
                    done_d  = 1'b1;
                end
            end
            default: to_idle = 1'b1;
        endcase
        if (to_idle) begin
            state_d = IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
            busy_d  = 1'b0;
            data_d  = 8'h00;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= 8'd0;
            csum_q  <= 8'd0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            data_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            csum_q  <= csum_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            data_q  <= data_d;
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign tx_valid_o = valid_q;
    assign tx_last_o  = last_q;
    assign tx_data_o  = data_q;

endmodule

// File: tb/tb_impl_id_tx.sv
// Directed bench for impl_id_tx: vector table for a full transfer plus hand sequences
// for back-pressure, held request, abort and mid-transfer reset.
module tb_impl_id_tx;

    logic       clk = 1'b0;
    logic       rst_n, req_i, abort_i, tx_ready_i;
    logic       busy_o, done_o, tx_valid_o, tx_last_o;
    logic [7:0] tx_data_o;

    int n_tests = 0;
    int n_fail  = 0;

    impl_id_tx #(.STR_LEN(30)) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req_i), .abort_i(abort_i),
        .busy_o(busy_o), .done_o(done_o), .tx_valid_o(tx_valid_o),
        .tx_ready_i(tx_ready_i), .tx_data_o(tx_data_o), .tx_last_o(tx_last_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n, req, abort, ready;
        logic       valid, last, busy, done;
        logic [7:0] data;
    } vec_t;

    vec_t       tv[$];
    logic [7:0] exp_b[31];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic add_vec(input logic r, input logic q, input logic a, input logic rd,
                           input logic v, input logic l, input logic b, input logic d,
                           input logic [7:0] dat);
        vec_t x;
        x.rst_n = r; x.req = q; x.abort = a; x.ready = rd;
        x.valid = v; x.last = l; x.busy = b; x.done = d; x.data = dat;
        tv.push_back(x);
    endtask

    // Runs one transfer from IDLE; ready asserted with probability pct%.
    task automatic xfer(input string name, input int pct, input bit hold_req);
        logic [7:0] got[$];
        logic       lasts[$];
        int         n_done = 0, unstable = 0, extra = 0, cyc = 0;
        bit         stalled = 0, finished = 0;
        logic [7:0] pd = 8'h00;
        logic       pl = 1'b0;
        @(negedge clk);
        req_i = 1'b1; tx_ready_i = 1'b0;
        while (!finished && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (!hold_req) req_i = 1'b0;
            if (stalled && tx_valid_o && (tx_data_o !== pd || tx_last_o !== pl)) unstable++;
            if (done_o) begin
                n_done++;
                finished = 1;
                req_i = 1'b0;
                tx_ready_i = 1'b0;
                if (tx_valid_o || busy_o) extra++;
            end else begin
                tx_ready_i = ($urandom_range(99) < pct);
                if (tx_valid_o && tx_ready_i) begin
                    got.push_back(tx_data_o);
                    lasts.push_back(tx_last_o);
                end
                stalled = tx_valid_o && !tx_ready_i;
                pd = tx_data_o; pl = tx_last_o;
            end
        end
        check({name, " finished"}, 32'(finished), 32'd1);
        repeat (3) begin
            @(negedge clk);
            if (done_o) n_done++;
            if (tx_valid_o || busy_o) extra++;
        end
        check({name, " handshakes"}, 32'(got.size()), 32'd31);
        if (got.size() == 31) begin
            int bad = 0;
            for (int i = 0; i < 31; i++)
                if (got[i] !== exp_b[i] || lasts[i] !== (i == 30)) bad++;
            check({name, " byte mismatches"}, 32'(bad), 32'd0);
        end
        check({name, " done pulses"}, 32'(n_done), 32'd1);
        check({name, " unstable stalls"}, 32'(unstable), 32'd0);
        check({name, " idle activity"}, 32'(extra), 32'd0);
    endtask

    initial begin
        string s;
        logic [7:0] cs;
`ifdef IMPL_ID_FOUNDRY_EN
        s = "Foundry implementation of baz.";
`else
        s = "Generic implementation of baz.";
`endif
        cs = 8'h00;
        for (int i = 0; i < 30; i++) begin
            exp_b[i] = s[i];
            cs ^= s[i];
        end
        exp_b[30] = cs;

        rst_n = 1'b0; req_i = 1'b0; abort_i = 1'b0; tx_ready_i = 1'b0;

        // Vectors: inputs applied before an edge, outputs expected just after it.
        add_vec(0, 0, 0, 0,  0, 0, 0, 0, 8'h00);
        add_vec(0, 1, 0, 1,  0, 0, 0, 0, 8'h00);
        add_vec(1, 1, 1, 1,  0, 0, 0, 0, 8'h00);   // abort wins over req in IDLE
        add_vec(1, 1, 0, 1,  1, 0, 1, 0, exp_b[0]);
        for (int i = 1; i < 30; i++) add_vec(1, 0, 0, 1,  1, 0, 1, 0, exp_b[i]);
        add_vec(1, 0, 0, 1,  1, 1, 1, 0, exp_b[30]);
        add_vec(1, 0, 0, 1,  0, 0, 0, 1, 8'h00);
        add_vec(1, 0, 0, 1,  0, 0, 0, 0, 8'h00);

        for (int k = 0; k < tv.size(); k++) begin
            @(negedge clk);
            rst_n = tv[k].rst_n; req_i = tv[k].req; abort_i = tv[k].abort;
            tx_ready_i = tv[k].ready;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d {valid,last,busy,done,data}", k),
                  {20'd0, tx_valid_o, tx_last_o, busy_o, done_o, tx_data_o},
                  {20'd0, tv[k].valid, tv[k].last, tv[k].busy, tv[k].done, tv[k].data});
        end
        check("byte29 is '.'", 32'(exp_b[29]), 32'h2E);

        xfer("full_rate", 100, 0);
        xfer("backpressure", 30, 0);
        xfer("held_req", 100, 1);
        xfer("second_req", 100, 0);

        // Abort coinciding with the byte-10 handshake.
        @(negedge clk);
        req_i = 1'b1; tx_ready_i = 1'b1;
        @(negedge clk);
        req_i = 1'b0;
        repeat (10) @(negedge clk);
        check("abort pre data", 32'(tx_data_o), 32'(exp_b[10]));
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        check("abort valid/busy/done", {29'd0, tx_valid_o, busy_o, done_o}, 32'd0);
        begin
            int dn = 0;
            repeat (3) begin
                @(negedge clk);
                if (done_o || tx_valid_o) dn++;
            end
            check("abort quiet after", 32'(dn), 32'd0);
        end
        req_i = 1'b1;
        @(negedge clk);
        req_i = 1'b0;
        check("restart byte0", {23'd0, tx_valid_o, tx_data_o}, {23'd0, 1'b1, exp_b[0]});

        // Reset while presenting the checksum.
        repeat (30) @(negedge clk);
        check("in CSUM", {23'd0, tx_last_o, tx_data_o}, {23'd0, 1'b1, exp_b[30]});
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("reset in CSUM outputs",
              {19'd0, busy_o, done_o, tx_valid_o, tx_last_o, tx_data_o}, 32'd0);
        @(negedge clk);
        check("reset in CSUM no done", {30'd0, done_o, tx_valid_o}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/impl_id_tx.md
# impl_id_tx

Implementation-identification transmitter. On request it streams a fixed ASCII identification string, followed by an XOR checksum byte, over a byte-wide valid/ready interface. The string names which implementation variant was compiled in. A top-level bench or debug reader consumes the stream to confirm which variant is integrated, without hierarchical peeking. The block sits alongside the configurable sub-module it describes, and its string is chosen by the same build configuration.

## Interface
Parameters:
- `STR_LEN`, 30: number of string bytes, excluding the checksum. Legal range 1..255.

Ports:
- `clk`, input, 1: the single clock; all logic is rising-edge.
- `rst_n`, input, 1: synchronous, active-low reset, sampled on the `clk` rising edge.
- `req_i`, input, 1: start-transfer request, sampled each cycle.
- `abort_i`, input, 1: cancels an in-progress transfer.
- `busy_o`, output, 1: a transfer is in progress (any state other than IDLE).
- `done_o`, output, 1: one-cycle pulse after the checksum byte is accepted.
- `tx_valid_o`, output, 1: `tx_data_o` holds a valid byte.
- `tx_ready_i`, input, 1: the consumer accepts the byte this cycle.
- `tx_data_o`, output, 8: the current byte.
- `tx_last_o`, output, 1: the current byte is the checksum, i.e. the final byte.

## Operation
- State machine states: IDLE, SEND, CSUM.
- IDLE:
  - All outputs are low.
  - `req_i`=1 moves to SEND with `idx`=0 and `csum`=0.
- SEND:
  - `tx_valid_o`=1 and `tx_data_o`=ROM[`idx`].
  - On a handshake (`tx_valid_o && tx_ready_i`), `csum` ^= ROM[`idx`].
  - On a handshake with `idx` < `STR_LEN`-1, `idx` increments.
  - On a handshake with `idx` == `STR_LEN`-1, move to CSUM.
- CSUM:
  - `tx_valid_o`=1, `tx_last_o`=1, `tx_data_o`=`csum`.
  - On a handshake, move to IDLE and assert `done_o` for exactly one cycle.
- Counters:
  - `idx` is 8 bits wide and never wraps; the SEND→CSUM transition happens before overflow.
  - `csum` is 8 bits wide.
- `req_i` while busy: ignored; there is no queuing and no restart.
- `req_i` in the same cycle as the CSUM handshake: ignored. A new transfer needs `req_i` in a cycle in which the state is IDLE.
- `abort_i`=1 in SEND or CSUM:
  - Next state is IDLE.
  - `tx_valid_o` drops on the next cycle and `done_o` is not asserted.
  - `abort_i` takes priority over a simultaneous handshake; that byte counts as not transferred.
- `abort_i` in IDLE: has no effect, and it takes priority over a simultaneous `req_i`.
- ROM:
  - Constant contents, indexed 0..`STR_LEN`-1.
  - The content is selected by the configuration macro.
  - Bytes beyond the string length read as 0x00 and are never sent.

## Timing
- Reset values: state=IDLE, `idx`=0, `csum`=0, and all outputs low (`busy_o`, `done_o`, `tx_valid_o`, `tx_last_o` = 0; `tx_data_o`=0x00).
- Reset mid-transfer: returns to IDLE on that edge. No `done_o` pulse, no partial checksum output.
- Latency:
  - `req_i` high at edge N gives `tx_valid_o`=1 with byte 0 from edge N onward, i.e. in cycle N+1.
  - `busy_o` rises in the same cycle as `tx_valid_o`.
- Throughput: one byte per cycle when `tx_ready_i` is held high. A full transfer is `STR_LEN`+1 cycles.
- Stability: while `tx_valid_o && !tx_ready_i`, `tx_data_o` and `tx_last_o` hold constant (abort excepted).
- `done_o` is asserted in the cycle after the CSUM handshake. In that same cycle `busy_o`=0 and `tx_valid_o`=0.
- All outputs are registered; there is no combinational path from `tx_ready_i` to `tx_valid_o`.

## Configuration
- `IMPL_ID_FOUNDRY_EN` defined: the ROM holds "Foundry implementation of baz." (30 bytes; byte 0 = 0x46).
- `IMPL_ID_FOUNDRY_EN` undefined: the ROM holds "Generic implementation of baz." (30 bytes; byte 0 = 0x47).
- Both strings are 30 bytes, so the default `STR_LEN` is valid in both builds.

## Test plan
- Reset, then `req_i` pulse with `tx_ready_i`=1 (macro undefined):
  - 31 consecutive beats, first byte 0x47, byte 29 = 0x2E ('.').
  - Beat 30 has `tx_last_o`=1 and data equal to the model XOR of bytes 0..29.
  - `done_o` pulses once on the following cycle.
- Same stimulus with the macro defined:
  - First byte 0x46, remaining bytes match "oundry implementation of baz.", checksum matches the model.
- Back-pressure: `tx_ready_i` random at 30%; data and last stay stable while stalled; the byte sequence is identical to the no-stall run; total handshakes = 31.
- `req_i` held high for the entire transfer: exactly one transfer and one `done_o`. Then `req_i` asserted while IDLE starts a second identical transfer with `csum` restarted at 0.
- `abort_i` asserted at byte 10 simultaneously with a handshake:
  - `tx_valid_o`=0 on the next cycle, no `done_o`.
  - The next request restarts at byte 0 (0x47).
- `rst_n`=0 for one cycle in CSUM: all outputs are 0 the next cycle, and no `done_o`.
